stbus_frame_sequencer: RTL and testbench

Frame-timing controller for the ST-BUS/DT serial converter datapath. Tracks the F0 frame pulse on the C4 clock, maintains the slot and bit position, and issues load, shift and sample strobes to the converter's TX and RX shift registers for one selected TX slot and one selected RX slot. Raises the CPU interrupt when a received byte is complete, and supervises frame sync.

---
 rtl/stbus_pkg.sv | 23 ++
 rtl/stbus_sync_fsm.sv | 82 ++++++++
 rtl/stbus_frame_sequencer.sv | 113 +++++++++++
 tb/tb_stbus_frame_sequencer.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stbus_pkg.sv
// Shared constants and types for the ST-BUS frame sequencer.
// Frame geometry is derived from the channel and bit counts.
package stbus_pkg;

  localparam int CHANNELS  = 32;
  localparam int BITS      = 8;
  localparam int MISS_MAX  = 3;
  localparam int SLOT_W    = 5;
  localparam int BIT_W     = $clog2(BITS);
  localparam int FRAME_LEN = 2 * CHANNELS * BITS;
  localparam int CNT_W     = $clog2(FRAME_LEN);
  localparam int MISS_W    = $clog2(MISS_MAX);

  typedef enum logic {
    HUNT,
    LOCKED
  } state_e;

  typedef logic [SLOT_W-1:0] slot_t;
  typedef logic [CNT_W-1:0]  cnt_t;
  typedef logic [MISS_W-1:0] miss_t;

endpackage

// File: rtl/stbus_sync_fsm.sv
// Frame sync supervisor: tracks F0, owns the frame counter,
// missed-pulse count and misalignment error counter.
module stbus_sync_fsm
  import stbus_pkg::*;
(
  input  logic       c4,
  input  logic       reset,
  input  logic       f0_i,
  output cnt_t       cnt_o,
  output logic       locked_o,
  output logic       frame_start_o,
  output logic       frame_err_o,
  output logic [7:0] err_cnt_o
);

  localparam cnt_t  LAST  = cnt_t'(FRAME_LEN - 1);
  localparam miss_t MLAST = miss_t'(MISS_MAX - 1);

  state_e     state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  miss_t      miss_q, miss_d;
  logic [7:0] err_q, err_d;
  logic       ferr_q, ferr_d;

  always_ff @(posedge c4) begin
    if (reset) begin
      state_q <= HUNT;
      cnt_q   <= '0;
      miss_q  <= '0;
      err_q   <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      miss_q  <= miss_d;
      err_q   <= err_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    miss_d  = miss_q;
    err_d   = err_q;
    ferr_d  = 1'b0;
    unique case (state_q)
      HUNT: begin
        cnt_d  = '0;
        miss_d = '0;
        if (!f0_i) state_d = LOCKED;
      end
      LOCKED: begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + cnt_t'(1);
        if (!f0_i) begin
          cnt_d  = '0;
          miss_d = '0;
          if (cnt_q != LAST) begin
            ferr_d = 1'b1;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end
        end else if (cnt_q == LAST) begin
          // third missed wrap in a row drops sync
          if (miss_q == MLAST) begin
            state_d = HUNT;
            miss_d  = '0;
          end else begin
            miss_d = miss_q + miss_t'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  assign cnt_o         = cnt_q;
  assign locked_o      = (state_q == LOCKED);
  assign frame_start_o = locked_o && (cnt_q == '0);
  assign frame_err_o   = ferr_q;
  assign err_cnt_o     = err_q;

endmodule

// File: rtl/stbus_frame_sequencer.sv
// ST-BUS frame sequencer: decodes TX/RX strobes from the frame
// counter for one TX and one RX slot and raises the RX interrupt.
module stbus_frame_sequencer
  import stbus_pkg::*;
(
  input  logic              c4,
  input  logic              reset,
  input  logic              f0,
  input  logic              enable,
  input  logic [SLOT_W-1:0] tx_slot,
  input  logic [SLOT_W-1:0] rx_slot,
  input  logic              int_ack,
  output logic              locked,
  output logic              frame_start,
  output logic [SLOT_W-1:0] slot_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              tx_load,
  output logic              tx_shift,
  output logic              tx_oe,
  output logic              rx_sample,
  output logic              rx_done,
  output logic              cpu_int,
  output logic              overrun,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  cnt_t  cnt;
  slot_t cur_slot, tx_s, rx_s;
  slot_t tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic  act, start, tx_hit, rx_hit;
  logic  armed_q, armed_d, done_q, done_d;
  logic  int_q, int_d, ovr_q, ovr_d;

  stbus_sync_fsm u_sync (
    .c4            (c4),
    .reset         (reset),
    .f0_i          (f0),
    .cnt_o         (cnt),
    .locked_o      (locked),
    .frame_start_o (frame_start),
    .frame_err_o   (frame_err),
    .err_cnt_o     (err_cnt)
  );

  assign cur_slot = cnt[CNT_W-1:BIT_W+1];
  assign slot_cnt = cur_slot;
  assign bit_cnt  = cnt[BIT_W:1];
  assign start    = (cnt == '0);
  assign act      = locked && enable;

  // slot 0 strobes fire in the capture cycle, so bypass the shadow
  assign tx_s = start ? tx_slot : tx_sh_q;
  assign rx_s = start ? rx_slot : rx_sh_q;

  assign tx_hit    = act && (cur_slot == tx_s);
  assign rx_hit    = act && (cur_slot == rx_s);
  assign tx_load   = tx_hit && (cnt[BIT_W:0] == '0);
  assign tx_shift  = tx_hit && !cnt[0] && (bit_cnt != '0);
  assign tx_oe     = tx_hit;
  assign rx_sample = rx_hit && cnt[0];
  assign rx_done   = done_q && act;
  assign cpu_int   = int_q;
  assign overrun   = ovr_q;

  always_comb begin
    tx_sh_d = start ? tx_slot : tx_sh_q;
    rx_sh_d = start ? rx_slot : rx_sh_q;
    armed_d = armed_q;
    done_d  = 1'b0;
    if (!act) begin
      armed_d = 1'b0;
    end else if (rx_sample) begin
      unique case (1'b1)
        (bit_cnt == '0): armed_d = 1'b1;
        (bit_cnt == BIT_W'(BITS - 1)): begin
          armed_d = 1'b0;
          done_d  = armed_q;
        end
        default: armed_d = armed_q;
      endcase
    end
    int_d = int_q;
    ovr_d = ovr_q;
    if (int_ack) begin
      int_d = 1'b0;
      ovr_d = 1'b0;
    end
    if (rx_done) begin
      int_d = 1'b1;
      if (int_q && !int_ack) ovr_d = 1'b1;
    end
  end

  always_ff @(posedge c4) begin
    if (reset) begin
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      armed_q <= 1'b0;
      done_q  <= 1'b0;
      int_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      armed_q <= armed_d;
      done_q  <= done_d;
      int_q   <= int_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule

// File: tb/tb_stbus_frame_sequencer.sv
// Self-checking bench for the ST-BUS frame sequencer.
// Strobe events are scoreboarded against expected frame positions.
module tb_stbus_frame_sequencer;

  logic       c4, reset, f0, enable, int_ack;
  logic [4:0] tx_slot, rx_slot;
  logic       locked, frame_start;
  logic [4:0] slot_cnt;
  logic [2:0] bit_cnt;
  logic       tx_load, tx_shift, tx_oe, rx_sample, rx_done;
  logic       cpu_int, overrun, frame_err;
  logic [7:0] err_cnt;

  stbus_frame_sequencer dut (
    .c4          (c4),
    .reset       (reset),
    .f0          (f0),
    .enable      (enable),
    .tx_slot     (tx_slot),
    .rx_slot     (rx_slot),
    .int_ack     (int_ack),
    .locked      (locked),
    .frame_start (frame_start),
    .slot_cnt    (slot_cnt),
    .bit_cnt     (bit_cnt),
    .tx_load     (tx_load),
    .tx_shift    (tx_shift),
    .tx_oe       (tx_oe),
    .rx_sample   (rx_sample),
    .rx_done     (rx_done),
    .cpu_int     (cpu_int),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    int kind;
    int t;
  } ev_t;

  ev_t        exp_q[$];
  logic [4:0] mask;
  int         ecnt, abst, errors, checks;

  wire [25:0] all_o = {locked, frame_start, slot_cnt, bit_cnt,
                       tx_load, tx_shift, tx_oe, rx_sample, rx_done,
                       cpu_int, overrun, frame_err, err_cnt};
  wire [15:0] sync_o = {locked, frame_start, slot_cnt, bit_cnt,
                        tx_load, tx_shift, tx_oe, rx_sample, rx_done,
                        frame_err};

  initial c4 = 1'b0;
  always #5 c4 = ~c4;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, expected finish earlier");
    $fatal(1);
  end

  task automatic push(input int k, input int t);
    ev_t e;
    e.kind = k;
    e.t    = t;
    exp_q.push_back(e);
  endtask

  task automatic push_tx(input int s, input int base);
    for (int c = 16 * s; c < 16 * s + 16; c++) begin
      if (c == 16 * s) push(0, base + c);
      else if (c % 2 == 0) push(1, base + c);
      push(2, base + c);
    end
  endtask

  task automatic push_rx(input int r, input int base);
    for (int b = 0; b < 8; b++) push(3, base + 16 * r + 2 * b + 1);
    push(4, base + 16 * r + 16);
  endtask

  // scoreboard: every masked strobe must match the next expected event
  task automatic monitor();
    logic [4:0] v;
    ev_t        e;
    v = {rx_done, rx_sample, tx_oe, tx_shift, tx_load};
    for (int k = 0; k < 5; k++) begin
      if (mask[k] && v[k]) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL strobe_extra: kind %0d at t=%0d, none expected",
                   k, abst);
        end else begin
          e = exp_q.pop_front();
          if (e.kind !== k || e.t !== abst) begin
            errors++;
            $display("FAIL strobe: got kind %0d t=%0d, expected kind %0d t=%0d",
                     k, abst, e.kind, e.t);
          end
        end
      end
    end
  endtask

  task automatic tick(input logic f0v);
    f0 = f0v;
    @(posedge c4);
    #1;
    f0   = 1'b1;
    ecnt = f0v ? (ecnt + 1) % 512 : 0;
    abst++;
    monitor();
  endtask

  task automatic run(input int n);
    repeat (n) tick(ecnt == 511 ? 1'b0 : 1'b1);
  endtask

  task automatic run_to(input int c);
    do tick(ecnt == 511 ? 1'b0 : 1'b1);
    while (ecnt != c);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick(1'b1);
    checks++;
    if (all_o !== 26'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_o);
    end
    reset = 1'b0;
    repeat (2) tick(1'b1);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_hunt_locked: got %b expected 0", locked);
    end
    checks++;
    if (sync_o !== 16'd0) begin
      errors++;
      $display("FAIL reset_hunt_idle: got %h expected 0", sync_o);
    end
  endtask

  task automatic test_lock();
    int t0, fs;
    repeat (7) tick(1'b1);
    tick(1'b0);
    t0 = abst;
    checks++;
    if (locked !== 1'b1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL lock: got locked=%b fs=%b expected 1 1",
               locked, frame_start);
    end
    fs = 0;
    for (int i = 0; i < 511; i++) begin
      run(1);
      if (frame_start) fs++;
      if (ecnt == 87) begin
        checks++;
        if (slot_cnt !== 5'd5 || bit_cnt !== 3'd3) begin
          errors++;
          $display("FAIL slot_bit: got %0d/%0d expected 5/3",
                   slot_cnt, bit_cnt);
        end
      end
    end
    checks++;
    if (fs !== 0) begin
      errors++;
      $display("FAIL frame_start_extra: got %0d expected 0", fs);
    end
    run(1);
    checks++;
    if (frame_start !== 1'b1 || abst - t0 !== 512) begin
      errors++;
      $display("FAIL frame_start_period: got fs=%b dt=%0d expected 1 512",
               frame_start, abst - t0);
    end
  endtask

  task automatic test_tx();
    int base;
    tx_slot = 5'd3;
    run_to(100);
    run_to(0);
    base = abst;
    push_tx(3, base);
    mask = 5'b00111;
    run(512);
    mask = 5'b0;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL tx_missing: got %0d left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_slot_change();
    int base;
    tx_slot = 5'd2;
    run_to(300);
    run_to(0);
    base = abst;
    push(0, base + 32);
    push(0, base + 512 + 80);
    mask = 5'b00001;
    run_to(100);
    tx_slot = 5'd5;
    run_to(0);
    run_to(100);
    mask = 5'b0;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL slot_change_missing: got %0d left expected 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_rx_int();
    int base;
    run_to(300);
    rx_slot = 5'd31;
    int_ack = 1'b1;
    tick(1'b1);
    int_ack = 1'b0;
    checks++;
    if (cpu_int !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear0: got %b%b expected 00", cpu_int, overrun);
    end
    run_to(0);
    base = abst;
    push_rx(31, base);
    push_rx(31, base + 512);
    push_rx(31, base + 1024);
    mask = 5'b11000;
    run(513);
    checks++;
    if (cpu_int !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rx_int: got %b%b expected 10", cpu_int, overrun);
    end
    run_to(0);
    run(1);
    checks++;
    if (cpu_int !== 1'b1 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun: got %b%b expected 11", cpu_int, overrun);
    end
    run_to(0);
    int_ack = 1'b1;
    run(1);
    checks++;
    if (cpu_int !== 1'b1 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL done_ack_same: got %b%b expected 10",
               cpu_int, overrun);
    end
    run(1);
    int_ack = 1'b0;
    checks++;
    if (cpu_int !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: got %b%b expected 00", cpu_int, overrun);
    end
    mask = 5'b0;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rx_missing: got %0d left expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_enable();
    int base;
    rx_slot = 5'd4;
    run_to(300);
    run_to(0);
    base = abst;
    push(3, base + 65);
    push(3, base + 67);
    mask = 5'b11000;
    run_to(68);
    enable = 1'b0;
    run_to(100);
    enable = 1'b1;
    run_to(300);
    mask = 5'b0;
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL enable_missing: got %0d left expected 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset_mid();
    int base;
    rx_slot = 5'd15;
    run_to(0);
    base = abst;
    for (int b = 0; b < 5; b++) push(3, base + 241 + 2 * b);
    mask = 5'b11000;
    run_to(250);
    reset = 1'b1;
    tick(1'b1);
    checks++;
    if (all_o !== 26'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", all_o);
    end
    repeat (2) tick(1'b1);
    reset = 1'b0;
    repeat (300) tick(1'b1);
    mask = 5'b0;
    checks++;
    if (exp_q.size() !== 0 || cpu_int !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_rx: got left=%0d int=%b expected 0 0",
               exp_q.size(), cpu_int);
      exp_q.delete();
    end
    tick(1'b0);
  endtask

  task automatic test_frame_err();
    run_to(200);
    tick(1'b0);
    checks++;
    if (frame_err !== 1'b1 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL frame_err: got fe=%b cnt=%0d expected 1 1",
               frame_err, err_cnt);
    end
    checks++;
    if (slot_cnt !== 5'd0 || bit_cnt !== 3'd0 || locked !== 1'b1) begin
      errors++;
      $display("FAIL realign: got slot=%0d bit=%0d lk=%b expected 0 0 1",
               slot_cnt, bit_cnt, locked);
    end
    tick(1'b1);
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL frame_err_pulse: got %b expected 0", frame_err);
    end
    for (int i = 2; i <= 256; i++) begin
      repeat (3) tick(1'b1);
      tick(1'b0);
      if (i == 255) begin
        checks++;
        if (err_cnt !== 8'd255) begin
          errors++;
          $display("FAIL err_cnt_255: got %0d expected 255", err_cnt);
        end
      end
    end
    checks++;
    if (err_cnt !== 8'd255 || frame_err !== 1'b1) begin
      errors++;
      $display("FAIL err_cnt_sat: got %0d fe=%b expected 255 1",
               err_cnt, frame_err);
    end
  endtask

  task automatic test_miss();
    int bad;
    for (int m = 1; m <= 2; m++) begin
      repeat (512) tick(1'b1);
      checks++;
      if (locked !== 1'b1) begin
        errors++;
        $display("FAIL miss_%0d: got locked=%b expected 1", m, locked);
      end
    end
    repeat (511) tick(1'b1);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL miss_pre3: got locked=%b expected 1", locked);
    end
    tick(1'b1);
    checks++;
    if (sync_o !== 16'd0) begin
      errors++;
      $display("FAIL miss_drop: got %h expected 0", sync_o);
    end
    bad = 0;
    repeat (40) begin
      tick(1'b1);
      if (sync_o !== 16'd0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL hunt_idle: got %0d busy cycles expected 0", bad);
    end
    tick(1'b0);
    checks++;
    if (locked !== 1'b1 || frame_start !== 1'b1) begin
      errors++;
      $display("FAIL relock: got %b%b expected 11", locked, frame_start);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    ecnt    = 0;
    abst    = 0;
    mask    = 5'b0;
    reset   = 1'b1;
    f0      = 1'b1;
    enable  = 1'b1;
    int_ack = 1'b0;
    tx_slot = 5'd0;
    rx_slot = 5'd10;
    test_reset();
    test_lock();
    test_tx();
    test_slot_change();
    test_rx_int();
    test_enable();
    test_reset_mid();
    test_frame_err();
    test_miss();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
